// File: rtl/sync_ram_dp.sv
// Simple-dual-port synchronous RAM with post-reset zero-fill, selectable read-during-write and optional output register.
// Optional per-word even parity with error injection when SYNC_RAM_PARITY_EN is defined.
module sync_ram_dp #(
    parameter int WORD_SIZE    = 8,
    parameter int ADDRESS_SIZE = 4,
    parameter int RDW_MODE     = 0,
    parameter int OUT_REG      = 0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    WE,
    input  logic [ADDRESS_SIZE-1:0] WADDR,
    input  logic [WORD_SIZE-1:0]    DIN,
    input  logic                    RE,
    input  logic [ADDRESS_SIZE-1:0] RADDR,
    output logic [WORD_SIZE-1:0]    DOUT,
    output logic                    RVALID,
    output logic                    READY,
    output logic                    PERR,
    input  logic                    PERR_INJ
);

    localparam int DEPTH = 1 << ADDRESS_SIZE;

    typedef enum logic {INIT, RUN} state_t;

    state_t                  state, state_nxt;
    logic [ADDRESS_SIZE-1:0] init_cnt;
    logic                    ready;

    logic                    wr_en;
    logic [ADDRESS_SIZE-1:0] wr_addr;
    logic [WORD_SIZE-1:0]    wr_data;
    logic                    rd_en;
    logic                    bypass;
    logic [WORD_SIZE-1:0]    rd_data;
    logic                    rd_perr;

    logic [WORD_SIZE-1:0]    mem [DEPTH];

    logic                    s1_valid;
    logic [WORD_SIZE-1:0]    s1_data;
    logic                    s1_perr;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT) init_cnt <= init_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            INIT: if (init_cnt == '1) state_nxt = RUN;
            RUN:  ready = 1'b1;
            default: state_nxt = INIT;
        endcase
    end

    assign READY = ready;

    // The zero-fill sequencer owns the write port until READY rises.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = WADDR;
        wr_data = DIN;
        if (!RST) begin
            if (state == INIT) begin
                wr_en   = 1'b1;
                wr_addr = init_cnt;
                wr_data = '0;
            end else if (WE) begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_en   = ready && RE && !RST;
    assign bypass  = (RDW_MODE != 0) && WE && (WADDR == RADDR);
    assign rd_data = bypass ? DIN : mem[RADDR];

`ifdef SYNC_RAM_PARITY_EN
    logic mem_p [DEPTH];
    logic wr_par;

    assign wr_par = (state == INIT) ? 1'b0 : ((^DIN) ^ PERR_INJ);

    always_ff @(posedge CLK) begin
        if (wr_en) mem_p[wr_addr] <= wr_par;
    end

    // Bypassed data carries freshly computed parity, so it cannot mismatch.
    assign rd_perr = bypass ? 1'b0 : ((^mem[RADDR]) ^ mem_p[RADDR]);
`else
    logic unused_perr_inj;
    assign unused_perr_inj = PERR_INJ;
    assign rd_perr         = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_perr  <= 1'b0;
        end else begin
            s1_valid <= rd_en;
            s1_perr  <= rd_en && rd_perr;
            if (rd_en) s1_data <= rd_data;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                 s2_valid;
            logic [WORD_SIZE-1:0] s2_data;
            logic                 s2_perr;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                    s2_perr  <= 1'b0;
                end else begin
                    s2_valid <= s1_valid;
                    s2_perr  <= s1_valid && s1_perr;
                    if (s1_valid) s2_data <= s1_data;
                end
            end

            assign DOUT   = s2_data;
            assign RVALID = s2_valid;
            assign PERR   = s2_perr;
        end else begin : g_no_out_reg
            assign DOUT   = s1_data;
            assign RVALID = s1_valid;
            assign PERR   = s1_perr;
        end
    endgenerate

endmodule

// File: doc/sync_ram_dp.md
Name: sync_ram_dp

Overview:
- Parametrised simple-dual-port synchronous RAM: one write port and one read port, both on one clock.
- Next generation of the single-port `memory` block. Adds:
  - explicit write/read enables;
  - selectable read-during-write behaviour;
  - optional output pipeline register;
  - read-valid tracking;
  - hardware zero-initialisation sequencer after reset.
- Used as the storage primitive under FIFOs and lookup tables in the datapath.

Parameters:
- WORD_SIZE, 8, data width in bits (>=1).
- ADDRESS_SIZE, 4, address width; depth = 2^ADDRESS_SIZE words (>=1).
- RDW_MODE, 0, same-address read/write collision: 0 = read returns old data, 1 = read returns DIN (write-first).
- OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, latency 2 cycles.

Ports:
- CLK  input  1  clock, all logic on posedge.
- RST  input  1  synchronous reset, active-high.
- WE  input  1  write enable.
- WADDR  input  ADDRESS_SIZE  write address.
- DIN  input  WORD_SIZE  write data.
- RE  input  1  read enable.
- RADDR  input  ADDRESS_SIZE  read address.
- DOUT  output  WORD_SIZE  read data, qualified by RVALID.
- RVALID  output  1  DOUT holds data for an accepted read.
- READY  output  1  initialisation complete; WE/RE accepted only when high.
- PERR  output  1  parity error flag; meaningful only with SYNC_RAM_PARITY_EN, else tied 0.
- PERR_INJ  input  1  parity-error injection for test; ignored without SYNC_RAM_PARITY_EN.

Behaviour:
- Reset (RST high at posedge):
  - DOUT=0, RVALID=0, READY=0, PERR=0.
  - All pipeline stages cleared; init FSM forced to INIT with init counter=0.
  - Array contents not reset directly.
- FSM states INIT and RUN:
  - INIT: each cycle writes 0 (and parity 0) to address = init counter, then increments the counter. After writing address 2^ADDRESS_SIZE-1, go to RUN.
  - INIT therefore lasts exactly 2^ADDRESS_SIZE cycles after the first posedge with RST low.
  - RUN: READY=1. Only RST leaves RUN.
- While READY=0: WE and RE are ignored; no user write occurs and no RVALID is generated.
- Write: WE=1 and READY=1 at posedge → mem[WADDR] <= DIN.
- Read: RE=1 and READY=1 at posedge → read accepted.
  - OUT_REG=0: DOUT=mem[RADDR] and RVALID=1 after that edge.
  - OUT_REG=1: same, one edge later.
  - One read per cycle, fully pipelined; back-to-back reads give back-to-back RVALID.
- When no read completes: RVALID=0 and DOUT holds its last value (no change to 0).
- Collision (WE=1, RE=1, WADDR==RADDR, same edge):
  - RDW_MODE=0: old content returned.
  - RDW_MODE=1: DIN returned.
  - The write always takes effect.
- Different-address simultaneous read and write: independent, no interaction.
- Addresses wrap naturally; no out-of-range case exists.
- Reset mid-operation (during INIT or with reads in flight): in-flight reads dropped (RVALID=0 next cycle), INIT restarts from address 0.

Optional Feature:
- Macro: SYNC_RAM_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit computed from DIN; with PERR_INJ=1 on a write, the stored parity bit is inverted.
  - On each read, stored parity is checked against the data read.
  - PERR is set in the same cycle as RVALID when they mismatch, cleared with RVALID otherwise, and follows the OUT_REG latency.
  - RDW_MODE=1 bypass uses parity of DIN and is never flagged.
- Undefined: no parity storage; PERR constant 0; PERR_INJ unused.

Test Plan:
- Init (ADDRESS_SIZE=4): deassert RST → READY low for exactly 16 cycles, then high. Read all 16 addresses → DOUT=0 each, RVALID one per read.
- Write/read latency (WORD_SIZE=8): write 0xA5 @3, then RE @3.
  - OUT_REG=0: RVALID and DOUT=0xA5 one cycle after RE.
  - OUT_REG=1: two cycles after RE.
- Collision: mem[5]=0x11; same-edge WE(5,0x22)+RE(5).
  - RDW_MODE=0 → DOUT=0x11.
  - RDW_MODE=1 → DOUT=0x22.
  - Subsequent read @5 → 0x22 in both modes.
- Gating: WE/RE asserted during INIT → no RVALID; location reads 0 after READY.
- Reset mid-flight: RE @2 then RST on the next edge → RVALID never asserts; READY drops and INIT restarts (16 cycles).
- Parity (SYNC_RAM_PARITY_EN): write 0x0F @7 with PERR_INJ=1, read @7 → PERR=1 with RVALID. Rewrite @7 with PERR_INJ=0, read → PERR=0.
